// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_reg
// Purpose  : ID/EX pipeline register. It captures the decoded control bundle,
//            operands and register addresses for the execute stage. It also
//            assembles two-word instructions (opcode word plus immediate word)
//            into a single execute-stage entry.
// Revision : 1.0  initial release
// ============================================================================
module id_ex_stage_reg #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              kill,
  input  logic              in_valid,
  input  logic              imm_fetch,
  input  logic [3:0]        mem_in,
  input  logic [5:0]        ex_in,
  input  logic [2:0]        wb_in,
  input  logic [DATA_W-1:0] rs1_data_in,
  input  logic [DATA_W-1:0] rs2_data_in,
  input  logic [REG_AW-1:0] rs1_addr_in,
  input  logic [REG_AW-1:0] rs2_addr_in,
  input  logic [REG_AW-1:0] rdst_addr_in,
  input  logic [DATA_W-1:0] instr_word,
  output logic [3:0]        mem_out,
  output logic [5:0]        ex_out,
  output logic [2:0]        wb_out,
  output logic [DATA_W-1:0] rs1_data_out,
  output logic [DATA_W-1:0] rs2_data_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [REG_AW-1:0] rs1_addr_out,
  output logic [REG_AW-1:0] rs2_addr_out,
  output logic [REG_AW-1:0] rdst_addr_out,
  output logic              valid_out,
  output logic              imm_pending
);

  typedef enum logic [0:0] {
    NORMAL   = 1'b0,
    WAIT_IMM = 1'b1
  } state_t;

  state_t state;

  // Opcode word of a two-word instruction, parked until its immediate arrives
  logic [3:0]        hold_mem;
  logic [5:0]        hold_ex;
  logic [2:0]        hold_wb;
  logic [DATA_W-1:0] hold_rs1_data;
  logic [DATA_W-1:0] hold_rs2_data;
  logic [REG_AW-1:0] hold_rs1_addr;
  logic [REG_AW-1:0] hold_rs2_addr;
  logic [REG_AW-1:0] hold_rdst_addr;

  // Decoded from state only, so decode sees no input-to-output path
  assign imm_pending = (state == WAIT_IMM);

  // Stage register, hold registers and assembly state machine
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      state          <= NORMAL;
      mem_out        <= '0;
      ex_out         <= '0;
      wb_out         <= '0;
      rs1_data_out   <= '0;
      rs2_data_out   <= '0;
      imm_out        <= '0;
      rs1_addr_out   <= '0;
      rs2_addr_out   <= '0;
      rdst_addr_out  <= '0;
      valid_out      <= 1'b0;
      hold_mem       <= '0;
      hold_ex        <= '0;
      hold_wb        <= '0;
      hold_rs1_data  <= '0;
      hold_rs2_data  <= '0;
      hold_rs1_addr  <= '0;
      hold_rs2_addr  <= '0;
      hold_rdst_addr <= '0;
    end else if (!stall) begin
      // Bubble unless a real entry is released below
      mem_out       <= '0;
      ex_out        <= '0;
      wb_out        <= '0;
      rs1_data_out  <= '0;
      rs2_data_out  <= '0;
      imm_out       <= '0;
      rs1_addr_out  <= '0;
      rs2_addr_out  <= '0;
      rdst_addr_out <= '0;
      valid_out     <= 1'b0;
      case (state)
        NORMAL: begin
          if (in_valid && imm_fetch) begin
            hold_mem       <= mem_in;
            hold_ex        <= ex_in;
            hold_wb        <= wb_in;
            hold_rs1_data  <= rs1_data_in;
            hold_rs2_data  <= rs2_data_in;
            hold_rs1_addr  <= rs1_addr_in;
            hold_rs2_addr  <= rs2_addr_in;
            hold_rdst_addr <= rdst_addr_in;
            state          <= WAIT_IMM;
          end else if (in_valid) begin
            mem_out       <= mem_in;
            ex_out        <= ex_in;
            wb_out        <= wb_in;
            rs1_data_out  <= rs1_data_in;
            rs2_data_out  <= rs2_data_in;
            rs1_addr_out  <= rs1_addr_in;
            rs2_addr_out  <= rs2_addr_in;
            rdst_addr_out <= rdst_addr_in;
            valid_out     <= 1'b1;
          end
        end
        WAIT_IMM: begin
          // The decode slot holds the immediate; its decoded fields are meaningless
          if (in_valid) begin
            mem_out       <= hold_mem;
            ex_out        <= hold_ex;
            wb_out        <= hold_wb;
            rs1_data_out  <= hold_rs1_data;
            rs2_data_out  <= hold_rs2_data;
            rs1_addr_out  <= hold_rs1_addr;
            rs2_addr_out  <= hold_rs2_addr;
            rdst_addr_out <= hold_rdst_addr;
            imm_out       <= instr_word;
            valid_out     <= 1'b1;
            state         <= NORMAL;
          end
        end
        default: state <= NORMAL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage_reg
// Purpose  : Directed scoreboard bench for id_ex_stage_reg. The driver pushes
//            the hand-computed expected stage contents after each edge, and
//            the monitor pops and compares them against the DUT outputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_stage_reg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  logic              clk = 1'b0;
  logic              rst, stall, kill, in_valid, imm_fetch;
  logic [3:0]        mem_in;
  logic [5:0]        ex_in;
  logic [2:0]        wb_in;
  logic [DATA_W-1:0] rs1_data_in, rs2_data_in, instr_word;
  logic [REG_AW-1:0] rs1_addr_in, rs2_addr_in, rdst_addr_in;
  logic [3:0]        mem_out;
  logic [5:0]        ex_out;
  logic [2:0]        wb_out;
  logic [DATA_W-1:0] rs1_data_out, rs2_data_out, imm_out;
  logic [REG_AW-1:0] rs1_addr_out, rs2_addr_out, rdst_addr_out;
  logic              valid_out, imm_pending;

  typedef struct packed {
    logic [3:0]        mem;
    logic [5:0]        ex;
    logic [2:0]        wb;
    logic [DATA_W-1:0] rs1d;
    logic [DATA_W-1:0] rs2d;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs1a;
    logic [REG_AW-1:0] rs2a;
    logic [REG_AW-1:0] rda;
    logic              valid;
    logic              pend;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  id_ex_stage_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .kill(kill),
    .in_valid(in_valid), .imm_fetch(imm_fetch),
    .mem_in(mem_in), .ex_in(ex_in), .wb_in(wb_in),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in),
    .rdst_addr_in(rdst_addr_in), .instr_word(instr_word),
    .mem_out(mem_out), .ex_out(ex_out), .wb_out(wb_out),
    .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
    .imm_out(imm_out), .rs1_addr_out(rs1_addr_out),
    .rs2_addr_out(rs2_addr_out), .rdst_addr_out(rdst_addr_out),
    .valid_out(valid_out), .imm_pending(imm_pending)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [3:0] m, logic [5:0] e, logic [2:0] w,
                              logic [15:0] d1, logic [15:0] d2, logic [15:0] im,
                              logic [2:0] a1, logic [2:0] a2, logic [2:0] ad,
                              logic v, logic p);
    exp_t r;
    r.mem = m; r.ex = e; r.wb = w; r.rs1d = d1; r.rs2d = d2; r.imm = im;
    r.rs1a = a1; r.rs2a = a2; r.rda = ad; r.valid = v; r.pend = p;
    return r;
  endfunction

  function automatic exp_t bubble(logic p);
    return mk(4'h0, 6'h0, 3'h0, 16'h0, 16'h0, 16'h0, 3'h0, 3'h0, 3'h0, 1'b0, p);
  endfunction

  // Drive one decode-slot word with control flags
  task automatic drive(logic r, logic s, logic k, logic v, logic f,
                       logic [3:0] m, logic [5:0] e, logic [2:0] w,
                       logic [15:0] d1, logic [15:0] d2,
                       logic [2:0] a1, logic [2:0] a2, logic [2:0] ad,
                       logic [15:0] iw);
    rst = r; stall = s; kill = k; in_valid = v; imm_fetch = f;
    mem_in = m; ex_in = e; wb_in = w; rs1_data_in = d1; rs2_data_in = d2;
    rs1_addr_in = a1; rs2_addr_in = a2; rdst_addr_in = ad; instr_word = iw;
  endtask

  // Advance one edge and queue what the stage must hold afterwards
  task automatic tick(exp_t e, string nm);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare the oldest queued expectation once per cycle
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = mk(mem_out, ex_out, wb_out, rs1_data_out, rs2_data_out, imm_out,
                rs1_addr_out, rs2_addr_out, rdst_addr_out, valid_out, imm_pending);
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got mem=%h ex=%h wb=%h d1=%h d2=%h imm=%h a1=%h a2=%h ad=%h v=%b p=%b expected mem=%h ex=%h wb=%h d1=%h d2=%h imm=%h a1=%h a2=%h ad=%h v=%b p=%b",
                   nm, a.mem, a.ex, a.wb, a.rs1d, a.rs2d, a.imm, a.rs1a, a.rs2a, a.rda, a.valid, a.pend,
                   e.mem, e.ex, e.wb, e.rs1d, e.rs2d, e.imm, e.rs1a, e.rs2a, e.rda, e.valid, e.pend);
        end
      end
    end
  end

  exp_t add_e, ldm_e;

  initial begin
    add_e = mk(4'b0000, 6'b001010, 3'b101, 16'h0005, 16'h0003, 16'h0000,
               3'd1, 3'd3, 3'd2, 1'b1, 1'b0);

    // Reset with random inputs
    drive(1, $urandom_range(0, 1), $urandom_range(0, 1), 1, 1, 4'($urandom), 6'($urandom),
          3'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 3'($urandom),
          3'($urandom), 16'($urandom));
    tick(bubble(0), "reset");
    drive(1, 0, 0, 1, 0, 4'hF, 6'h3F, 3'h7, 16'hFFFF, 16'hFFFF, 3'h7, 3'h7, 3'h7, 16'hFFFF);
    tick(bubble(0), "reset_hold");

    // Single-word ADD pass-through, imm_out forced to zero
    drive(0, 0, 0, 1, 0, 4'b0000, 6'b001010, 3'b101, 16'h0005, 16'h0003, 3'd1, 3'd3, 3'd2, 16'hAAAA);
    tick(add_e, "add_pass");
    // Stall freezes a valid entry
    drive(0, 1, 0, 1, 0, 4'b0101, 6'h11, 3'b011, 16'h9999, 16'h8888, 3'd5, 3'd6, 3'd7, 16'h7777);
    tick(add_e, "stall_valid");
    // NORMAL with no valid word produces a bubble
    drive(0, 0, 0, 0, 0, 4'b0101, 6'h11, 3'b011, 16'h9999, 16'h8888, 3'd5, 3'd6, 3'd7, 16'h7777);
    tick(bubble(0), "normal_idle");

    // LDM assembly; decoded fields of the immediate slot are junk and ignored
    ldm_e = mk(4'b1000, 6'b000000, 3'b110, 16'h0010, 16'h0020, 16'hBEEF,
               3'd0, 3'd1, 3'd4, 1'b1, 1'b0);
    drive(0, 0, 0, 1, 1, 4'b1000, 6'b000000, 3'b110, 16'h0010, 16'h0020, 3'd0, 3'd1, 3'd4, 16'h5555);
    tick(bubble(1), "ldm_op");
    drive(0, 0, 0, 1, 1, 4'b0111, 6'b111111, 3'b001, 16'hDEAD, 16'hCAFE, 3'd7, 3'd6, 3'd5, 16'hBEEF);
    tick(ldm_e, "ldm_imm");

    // Stall for three cycles inside WAIT_IMM, then release
    drive(0, 0, 0, 1, 1, 4'b1000, 6'b000000, 3'b110, 16'h0010, 16'h0020, 3'd0, 3'd1, 3'd4, 16'h5555);
    tick(bubble(1), "stall_ldm_op");
    drive(0, 1, 0, 1, 0, 4'b0011, 6'h05, 3'b010, 16'h1111, 16'h2222, 3'd3, 3'd3, 3'd3, 16'h1234);
    for (int i = 0; i < 3; i++) tick(bubble(1), "stall_wait");
    stall = 0;
    ldm_e.imm = 16'h1234;
    tick(ldm_e, "stall_release");

    // Kill inside WAIT_IMM discards the held LDM
    drive(0, 0, 0, 1, 1, 4'b1000, 6'b000000, 3'b110, 16'h0010, 16'h0020, 3'd0, 3'd1, 3'd4, 16'h5555);
    tick(bubble(1), "kill_ldm_op");
    drive(0, 0, 1, 1, 0, 4'b1000, 6'b000000, 3'b110, 16'h0010, 16'h0020, 3'd0, 3'd1, 3'd4, 16'h4321);
    tick(bubble(0), "kill");
    drive(0, 0, 0, 1, 0, 4'b0000, 6'b001010, 3'b101, 16'h0005, 16'h0003, 3'd1, 3'd3, 3'd2, 16'h4321);
    tick(add_e, "add_after_kill");

    // Fetch gap between opcode and immediate
    drive(0, 0, 0, 1, 1, 4'b1000, 6'b000000, 3'b110, 16'h0010, 16'h0020, 3'd0, 3'd1, 3'd4, 16'h5555);
    tick(bubble(1), "gap_ldm_op");
    drive(0, 0, 0, 0, 0, 4'b0110, 6'h2A, 3'b111, 16'h3333, 16'h4444, 3'd2, 3'd2, 3'd2, 16'h6666);
    tick(bubble(1), "gap_idle");
    drive(0, 0, 0, 1, 0, 4'b0110, 6'h2A, 3'b111, 16'h3333, 16'h4444, 3'd2, 3'd2, 3'd2, 16'h00FF);
    ldm_e.imm = 16'h00FF;
    tick(ldm_e, "gap_imm");

    // Reset inside WAIT_IMM: next word is an opcode again
    drive(0, 0, 0, 1, 1, 4'b1000, 6'b000000, 3'b110, 16'h0010, 16'h0020, 3'd0, 3'd1, 3'd4, 16'h5555);
    tick(bubble(1), "rst_ldm_op");
    drive(1, 0, 0, 1, 0, 4'b0000, 6'b001010, 3'b101, 16'h0005, 16'h0003, 3'd1, 3'd3, 3'd2, 16'h0000);
    tick(bubble(0), "rst_in_wait");
    rst = 0;
    tick(add_e, "add_after_rst");

    drive(0, 0, 0, 0, 0, 4'h0, 6'h0, 3'h0, 16'h0, 16'h0, 3'h0, 3'h0, 3'h0, 16'h0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
